qs_lp_drain: RTL and testbench

QS_LP_DRAIN -- requirements
Module: qs_lp_drain

---
 rtl/qs_lp_drain.sv | 105 ++++++++++
 tb/tb_qs_lp_drain.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/qs_lp_drain.sv
// Single-slot output stage draining an upstream FIFO, with a Q-channel
// handshake that accepts quiesce once drained or denies after a timeout.
module qs_lp_drain #(
  parameter int DATA_W        = 4,
  parameter int DRAIN_TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fifo_empty_i,
  input  logic [DATA_W-1:0] fifo_data_i,
  output logic              fifo_pop_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_ready_i,
  input  logic              qreqn_i,
  output logic              qacceptn_o,
  output logic              qdeny_o,
  output logic              qactive_o
);

  typedef enum logic [2:0] {
    S_RUN, S_REQUEST, S_STOPPED, S_EXIT, S_DENIED, S_CONTINUE
  } state_t;

  localparam logic [7:0] CNT_MAX = 8'(DRAIN_TIMEOUT - 1);

  state_t            state_q;
  logic [7:0]        cnt_q;
  logic              acc_q, deny_q;
  logic              vld_q;
  logic [DATA_W-1:0] data_q;
  logic              pop_en, drained;

  // The FIFO is frozen only while quiesced or leaving quiescence.
  assign pop_en     = (state_q != S_STOPPED) && (state_q != S_EXIT);
  assign fifo_pop_o = !reset && !fifo_empty_i && (!vld_q || out_ready_i) && pop_en;
  assign drained    = fifo_empty_i && !vld_q;

  assign out_valid_o = vld_q;
  assign out_data_o  = data_q;
  assign qacceptn_o  = acc_q;
  assign qdeny_o     = deny_q;
  assign qactive_o   = !fifo_empty_i || vld_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else if (fifo_pop_o) begin
      vld_q  <= 1'b1;
      data_q <= fifo_data_i;
    end else if (vld_q && out_ready_i) begin
      vld_q  <= 1'b0;
    end
  end

  // Outputs are assigned alongside each transition so they track the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
      acc_q   <= 1'b1;
      deny_q  <= 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          cnt_q <= '0;
          if (!qreqn_i) state_q <= S_REQUEST;
        end
        S_REQUEST: begin
          if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 8'd1;
          if (qreqn_i) begin
            state_q <= S_RUN;
          end else if (drained) begin
            state_q <= S_STOPPED;
            acc_q   <= 1'b0;
          end else if (cnt_q == CNT_MAX) begin
            state_q <= S_DENIED;
            deny_q  <= 1'b1;
          end
        end
        S_STOPPED: begin
          if (qreqn_i) begin
            state_q <= S_EXIT;
            acc_q   <= 1'b1;
          end
        end
        S_EXIT: state_q <= S_RUN;
        S_DENIED: begin
          if (qreqn_i) begin
            state_q <= S_CONTINUE;
            deny_q  <= 1'b0;
          end
        end
        S_CONTINUE: state_q <= S_RUN;
        default: begin
          state_q <= S_RUN;
          acc_q   <= 1'b1;
          deny_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qs_lp_drain.sv
// Directed bench for qs_lp_drain: queue-backed FIFO, cycle-level reference
// model compared every cycle, plus literal spot checks of the key scenarios.
module tb_qs_lp_drain;
  localparam int DW = 4;
  localparam int T  = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          fifo_empty_i;
  logic [DW-1:0] fifo_data_i;
  logic          fifo_pop_o, out_valid_o, out_ready_i;
  logic [DW-1:0] out_data_o;
  logic          qreqn_i, qacceptn_o, qdeny_o, qactive_o;

  qs_lp_drain #(.DATA_W(DW), .DRAIN_TIMEOUT(T)) dut (
    .clk(clk), .reset(reset),
    .fifo_empty_i(fifo_empty_i), .fifo_data_i(fifo_data_i), .fifo_pop_o(fifo_pop_o),
    .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_ready_i(out_ready_i),
    .qreqn_i(qreqn_i), .qacceptn_o(qacceptn_o), .qdeny_o(qdeny_o), .qactive_o(qactive_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum int {M_RUN, M_REQ, M_STOP, M_EXIT, M_DENY, M_CONT} mstate_t;
  mstate_t       ms = M_RUN;
  bit            mv = 0;
  logic [DW-1:0] md = '0;
  int            cyc = 0;
  int            req_enter = 0;
  bit            mok = 0;

  function automatic bit m_pop();
    bit frozen = (ms == M_STOP) || (ms == M_EXIT);
    return !reset && !fifo_empty_i && (!mv || out_ready_i) && !frozen;
  endfunction

  always @(posedge clk) begin
    bit p, drained_now;
    p = m_pop();
    drained_now = fifo_empty_i && !mv;
    if (reset) begin
      ms = M_RUN; mv = 0; md = '0; mok = 1;
    end else begin
      if (p) begin md = fifo_data_i; mv = 1; end
      else if (mv && out_ready_i) mv = 0;
      case (ms)
        M_RUN:  if (!qreqn_i) begin ms = M_REQ; req_enter = cyc + 1; end
        M_REQ: begin
          if (qreqn_i) ms = M_RUN;
          else if (drained_now) ms = M_STOP;
          else if (cyc - req_enter == T - 1) ms = M_DENY;
        end
        M_STOP: if (qreqn_i) ms = M_EXIT;
        M_EXIT: ms = M_RUN;
        M_DENY: if (qreqn_i) ms = M_CONT;
        M_CONT: ms = M_RUN;
        default: ms = M_RUN;
      endcase
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (mok) begin
      chk("pop",     fifo_pop_o,  m_pop());
      chk("valid",   out_valid_o, mv);
      chk("data",    out_data_o,  md);
      chk("acceptn", qacceptn_o,  ms != M_STOP);
      chk("deny",    qdeny_o,     ms == M_DENY);
      chk("active",  qactive_o,   !fifo_empty_i || mv);
      chk("acc_deny_excl", !(!qacceptn_o && qdeny_o), 1);
    end
  end

  // ---------------- stimulus ----------------
  logic [DW-1:0] fifo_q[$];
  bit pop_seen;

  task automatic drive_fifo();
    fifo_empty_i = (fifo_q.size() == 0);
    fifo_data_i  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  task automatic push(input logic [DW-1:0] v);
    fifo_q.push_back(v);
    drive_fifo();
  endtask

  // Advance one clock; the FIFO head is consumed when the DUT popped.
  task automatic step();
    @(negedge clk);
    pop_seen = fifo_pop_o;
    @(posedge clk);
    #1;
    if (pop_seen && fifo_q.size() != 0) void'(fifo_q.pop_front());
    drive_fifo();
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1; out_ready_i = 1; qreqn_i = 1;
    drive_fifo();
    step(); step();
    push(4'hA);
    settle();
    chk("lit_reset_valid", out_valid_o, 0);
    chk("lit_reset_data",  out_data_o,  0);
    chk("lit_reset_acc",   qacceptn_o,  1);
    chk("lit_reset_deny",  qdeny_o,     0);
    chk("lit_reset_pop",   fifo_pop_o,  0);
    fifo_q.delete(); drive_fifo();
    reset = 0;
    step();

    // streaming 3,5,9
    push(3); push(5); push(9);
    settle(); chk("lit_s0_pop", fifo_pop_o, 1);
    step(); chk("lit_s1_data", out_data_o, 3);
    step(); chk("lit_s2_data", out_data_o, 5);
    step(); chk("lit_s3_data", out_data_o, 9); chk("lit_s3_valid", out_valid_o, 1);
    step(); chk("lit_s4_valid", out_valid_o, 0);

    // backpressure holding 6
    out_ready_i = 0; push(6);
    step();
    push(1); push(2);
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("lit_bp_pop", fifo_pop_o, 0);
      chk("lit_bp_data", out_data_o, 6);
      step();
    end
    out_ready_i = 1;
    settle(); chk("lit_bp_release_pop", fifo_pop_o, 1);
    repeat (4) step();

    // accept path, then wake while stopped
    push(4); push(8); qreqn_i = 0;
    repeat (4) step();
    chk("lit_acc_stopped", qacceptn_o, 0);
    push(7);
    settle();
    chk("lit_wake_active", qactive_o, 1);
    chk("lit_wake_nopop", fifo_pop_o, 0);
    step(); step();
    chk("lit_wake_nopop2", fifo_pop_o, 0);
    qreqn_i = 1;
    settle(); chk("lit_exit_pending_nopop", fifo_pop_o, 0);
    step();
    chk("lit_exit_acc", qacceptn_o, 1);
    chk("lit_exit_nopop", fifo_pop_o, 0);
    step(); chk("lit_run_pop7", fifo_pop_o, 1);
    step(); chk("lit_out7", out_data_o, 7); chk("lit_out7_valid", out_valid_o, 1);
    step(); step();

    // deny after timeout with output stalled
    out_ready_i = 0; push(6);
    step();
    qreqn_i = 0;
    step();
    for (int k = 0; k < T; k++) begin
      settle();
      chk("lit_deny_early", qdeny_o, 0);
      chk("lit_deny_acc", qacceptn_o, 1);
      step();
    end
    chk("lit_deny_at_T", qdeny_o, 1);
    chk("lit_deny_acc_T", qacceptn_o, 1);
    qreqn_i = 1;
    step(); chk("lit_continue_deny", qdeny_o, 0);
    step();
    out_ready_i = 1;
    repeat (3) step();

    // drained and timeout on the same cycle: drained wins
    out_ready_i = 0; push(4);
    step();
    qreqn_i = 0;
    step();
    repeat (T - 2) step();
    out_ready_i = 1;
    step();
    step();
    chk("lit_tie_acc", qacceptn_o, 0);
    chk("lit_tie_deny", qdeny_o, 0);
    qreqn_i = 1;
    step(); step(); step();

    // withdrawn request returns to RUN
    out_ready_i = 0; push(2);
    step();
    qreqn_i = 0; step();
    qreqn_i = 1; step(); step();
    out_ready_i = 1; repeat (3) step();

    // reset mid-REQUEST with a held payload
    out_ready_i = 0; push(5);
    step();
    qreqn_i = 0; step(); step();
    chk("lit_mid_valid", out_valid_o, 1);
    reset = 1; push(3);
    step();
    settle();
    chk("lit_rst_valid", out_valid_o, 0);
    chk("lit_rst_acc", qacceptn_o, 1);
    chk("lit_rst_deny", qdeny_o, 0);
    chk("lit_rst_pop", fifo_pop_o, 0);
    reset = 0; qreqn_i = 1; out_ready_i = 1;
    repeat (4) step();

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
